armleocpu_tlb_ctrl: RTL and testbench

//   Sequencer and arbiter in front of armleocpu_tlb. Shares the single TLB command port between a

---
 rtl/armleocpu_tlb_ctrl.sv | 78 +++++++
 tb/tb_armleocpu_tlb_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_tlb_ctrl.sv
// armleocpu_tlb_ctrl: arbitrates resolve, refill-write and full-flush traffic onto the single TLB command port
module armleocpu_tlb_ctrl #(
  parameter int ENTRIES_W      = 4,
  parameter bit FLUSH_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [19:0]          res_vaddr,
  output logic                 res_done,
  output logic                 res_hit,
  output logic [7:0]           res_accesstag,
  output logic [21:0]          res_phys,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [19:0]          wr_vaddr,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [1:0]           tlb_command,
  output logic [19:0]          tlb_vaddr,
  output logic [ENTRIES_W-1:0] tlb_invalidate_set_index,
  input  logic                 tlb_hit,
  input  logic [7:0]           tlb_accesstag_r,
  input  logic [21:0]          tlb_phys_r
);
  localparam logic [1:0] CMD_NONE       = 2'd0;
  localparam logic [1:0] CMD_RESOLVE    = 2'd1;
  localparam logic [1:0] CMD_WRITE      = 2'd2;
  localparam logic [1:0] CMD_INVALIDATE = 2'd3;
  typedef enum logic [1:0] {INIT, FLUSH, IDLE} state_t;
  state_t               state_q, state_d;
  logic [ENTRIES_W-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 res_done_q, res_done_d;
  logic                 flush_done_q, flush_done_d;
  logic                 idle, flush_go;
  // Flushes win over writes, writes over resolves; a flush request blocks both for that cycle
  always_comb begin
    idle                     = state_q == IDLE;
    flush_go                 = idle & (flush_req | pend_q);
    wr_ready                 = idle & ~flush_go & wr_valid;
    res_ready                = idle & ~flush_go & ~wr_valid & res_valid;
    tlb_command              = state_q == FLUSH ? CMD_INVALIDATE : wr_ready ? CMD_WRITE : res_ready ? CMD_RESOLVE : CMD_NONE;
    tlb_vaddr                = wr_ready ? wr_vaddr : res_ready ? res_vaddr : 20'd0;
    tlb_invalidate_set_index = cnt_q;
    flush_busy               = (state_q == FLUSH) | ((state_q == INIT) & FLUSH_ON_RESET) | pend_q;
    res_done                 = res_done_q;
    res_hit                  = tlb_hit & res_done_q;
    res_accesstag            = tlb_accesstag_r;
    res_phys                 = tlb_phys_r;
    flush_done               = flush_done_q;
    state_d                  = state_q == INIT  ? (FLUSH_ON_RESET ? FLUSH : IDLE) :
                               state_q == FLUSH ? (&cnt_q ? IDLE : FLUSH) :
                               (flush_go ? FLUSH : IDLE);
    cnt_d                    = state_q == FLUSH ? cnt_q + 1'b1 : cnt_q;
    pend_d                   = state_q == INIT ? (~FLUSH_ON_RESET & flush_req) : (pend_q & ~flush_go);
    res_done_d               = res_ready & res_valid;
    flush_done_d             = (state_q == FLUSH) & (&cnt_q);
  end
  // Sequencer state; an asynchronous reset aborts any flush pass without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      res_done_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      res_done_q   <= res_done_d;
      flush_done_q <= flush_done_d;
    end
  end
endmodule

// File: tb/tb_armleocpu_tlb_ctrl.sv
// tb_armleocpu_tlb_ctrl: directed and random checks of the TLB sequencer against a cycle-level reference
module tb_armleocpu_tlb_ctrl;
  localparam logic [1:0] NONE = 2'd0, RES = 2'd1, WR = 2'd2, INV = 2'd3;
  logic clk = 1'b0, rst = 1'b1;
  logic res_valid = 1'b0, wr_valid = 1'b0, flush_req = 1'b0;
  logic [19:0] res_vaddr = '0, wr_vaddr = '0;
  logic res_ready, res_done, res_hit, wr_ready, flush_busy, flush_done;
  logic [7:0] res_accesstag;
  logic [21:0] res_phys;
  logic [1:0] tlb_command;
  logic [19:0] tlb_vaddr;
  logic [3:0] tlb_invalidate_set_index;
  logic tlb_hit = 1'b0;
  logic [7:0] tlb_accesstag_r = '0;
  logic [21:0] tlb_phys_r = '0;
  logic [7:0] wr_acc = '0;
  logic [21:0] wr_phys = '0;
  logic tv [16] = '{default: 1'b1};
  logic [15:0] tt [16] = '{default: 16'h0};
  logic [7:0] ta [16] = '{default: 8'h0};
  logic [21:0] tp [16] = '{default: 22'h0};
  int vectors = 0, miscompares = 0;
  bit m_init, m_pend, m_fdone, m_acc, m_hit;
  int m_left;
  logic [21:0] m_phys;
  logic [7:0] m_tag;
  logic [1:0] last_cmd;
  logic last_rr, last_wr, last_fdone, last_done, last_hit;
  logic [3:0] last_idx;

  always #5 clk = ~clk;

  armleocpu_tlb_ctrl #(.ENTRIES_W(4), .FLUSH_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_vaddr(res_vaddr),
    .res_done(res_done), .res_hit(res_hit), .res_accesstag(res_accesstag), .res_phys(res_phys),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_vaddr(wr_vaddr),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .tlb_command(tlb_command), .tlb_vaddr(tlb_vaddr), .tlb_invalidate_set_index(tlb_invalidate_set_index),
    .tlb_hit(tlb_hit), .tlb_accesstag_r(tlb_accesstag_r), .tlb_phys_r(tlb_phys_r)
  );

  // Direct-mapped TLB stand-in: set = vaddr[3:0], tag = vaddr[19:4], registered read outputs
  always @(posedge clk) begin
    if (tlb_command == RES) begin
      tlb_hit         <= tv[tlb_vaddr[3:0]] && tt[tlb_vaddr[3:0]] == tlb_vaddr[19:4];
      tlb_accesstag_r <= ta[tlb_vaddr[3:0]];
      tlb_phys_r      <= tp[tlb_vaddr[3:0]];
    end else if (tlb_command == WR) begin
      tv[tlb_vaddr[3:0]] <= 1'b1;
      tt[tlb_vaddr[3:0]] <= tlb_vaddr[19:4];
      ta[tlb_vaddr[3:0]] <= wr_acc;
      tp[tlb_vaddr[3:0]] <= wr_phys;
    end else if (tlb_command == INV) begin
      tv[tlb_invalidate_set_index] <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_left = 0; m_pend = 0; m_fdone = 0; m_acc = 0; m_hit = 0;
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance the reference at the rising edge
  task automatic cycle(input bit wv, input logic [19:0] wa, input bit rv, input logic [19:0] ra, input bit fr);
    bit go, ew, er, eb, nh;
    logic [1:0] ec;
    logic [21:0] np;
    logic [7:0] nt;
    wr_valid = wv; wr_vaddr = wa; res_valid = rv; res_vaddr = ra; flush_req = fr;
    wr_acc = 8'($urandom); wr_phys = 22'($urandom);
    #1;
    go = !m_init && m_left == 0 && (fr || m_pend);
    ew = !m_init && m_left == 0 && !go && wv;
    er = !m_init && m_left == 0 && !go && !wv && rv;
    ec = m_left > 0 ? INV : ew ? WR : er ? RES : NONE;
    eb = m_init || m_left > 0 || m_pend;
    chk("cmd", tlb_command, ec);
    chk("wr_ready", wr_ready, ew);
    chk("res_ready", res_ready, er);
    chk("flush_busy", flush_busy, eb);
    chk("flush_done", flush_done, m_fdone);
    chk("res_done", res_done, m_acc);
    if (m_acc) begin
      chk("res_hit", res_hit, m_hit);
      if (m_hit) begin
        chk("res_phys", res_phys, m_phys);
        chk("res_accesstag", res_accesstag, m_tag);
      end
    end
    if (m_left > 0) chk("inv_idx", tlb_invalidate_set_index, 16 - m_left);
    if (ew || er) chk("vaddr", tlb_vaddr, ew ? wa : ra);
    if (m_init) chk("init_vaddr", tlb_vaddr, 0);
    last_cmd = tlb_command; last_rr = res_ready; last_wr = wr_ready; last_fdone = flush_done;
    last_done = res_done; last_hit = res_hit; last_idx = tlb_invalidate_set_index;
    nh = tv[ra[3:0]] && tt[ra[3:0]] == ra[19:4];
    np = tp[ra[3:0]];
    nt = ta[ra[3:0]];
    @(posedge clk);
    m_acc = er;
    if (er) begin m_hit = nh; m_phys = np; m_tag = nt; end
    m_fdone = 0;
    if (m_init) begin m_init = 0; m_left = 16; end
    else if (m_left > 0) begin m_left--; m_fdone = (m_left == 0); end
    else if (go) begin m_left = 16; m_pend = 0; end
    @(negedge clk);
  endtask

  initial begin
    int inv, rdy, dcyc, nd, nh2, n, fdn, first_idx;
    bit fd_at_acc, seen;
    model_reset();
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst_cmd", tlb_command, NONE);
    chk("rst_busy", flush_busy, 1);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_res_done", res_done, 0);
    chk("rst_flush_done", flush_done, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    inv = 0; rdy = 0; dcyc = 0;
    for (int c = 1; c <= 18; c++) begin
      cycle(c < 18, 20'h00005, c < 18, 20'h00007, 0);
      if (last_cmd == INV) inv++;
      if (c < 18 && (last_rr || last_wr)) rdy++;
      if (last_fdone && dcyc == 0) dcyc = c;
    end
    chk("boot_inv_count", inv, 16);
    chk("boot_done_cycle", dcyc, 18);
    chk("boot_no_ready", rdy, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 20'h0ABC3, 1, 20'h0ABC3, 0);
    chk("wr_first_cmd", last_cmd, WR);
    chk("wr_first_rr", last_rr, 0);
    cycle(0, 0, 1, 20'h0ABC3, 0);
    chk("rd_after_wr_cmd", last_cmd, RES);
    cycle(0, 0, 0, 0, 0);
    chk("rd_after_wr_done", last_done, 1);
    chk("rd_after_wr_hit", last_hit, 1);
    for (int i = 0; i < 3; i++) cycle(1, 20'h00010 + 20'(i), 0, 0, 0);
    nd = 0; nh2 = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, i < 3, 20'h00010 + 20'(i), 0);
      nd += int'(last_done);
      nh2 += int'(last_done && last_hit);
    end
    chk("pipe_done_count", nd, 3);
    chk("pipe_hit_count", nh2, 3);
    cycle(0, 0, 1, 20'h00010, 1);
    n = 1; fd_at_acc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 1, 20'h00010, 0);
      if (!last_rr) n++;
      else begin fd_at_acc = last_fdone; break; end
    end
    chk("flush_block_cycles", n, 17);
    chk("flush_done_at_accept", fd_at_acc, 1);
    cycle(0, 0, 0, 0, 0);
    chk("post_flush_done", last_done, 1);
    chk("post_flush_miss", last_hit, 0);
    cycle(0, 0, 0, 0, 1);
    fdn = 0; inv = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 0, 0, m_left == 11);
      fdn += int'(last_fdone);
      if (last_cmd == INV) inv++;
    end
    chk("merge_done_count", fdn, 1);
    chk("merge_inv_count", inv, 16);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("abort_cmd", tlb_command, NONE);
    chk("abort_busy", flush_busy, 1);
    chk("abort_flush_done", flush_done, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    fdn = 0; dcyc = 0; seen = 0; first_idx = -1;
    for (int c = 1; c <= 18; c++) begin
      cycle(0, 0, 0, 0, 0);
      if (last_cmd == INV && !seen) begin seen = 1; first_idx = int'(last_idx); end
      if (last_fdone) begin fdn++; if (dcyc == 0) dcyc = c; end
    end
    chk("restart_first_idx", first_idx, 0);
    chk("restart_done_count", fdn, 1);
    chk("restart_done_cycle", dcyc, 18);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) == 0, 20'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
            20'($urandom_range(0, 63)), $urandom_range(0, 39) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
